keypad_scan4x4: RTL

- Scans a 4x4 matrix keypad: drives one column at a time, reads the 4 rows, debounces, and emits a 4-bit hex key code with a one-cycle valid pulse.
- Keeps a 32-bit shift register of the last 8 keys entered, in the same packing the 8-digit seven-segment display driver uses for its disp_data input.
- Sits between the board keypad pins and user logic or the display driver.

---
 rtl/keypad_scan4x4.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner. It drives one column low at a time, samples the
// synchronised rows on each scan tick, and debounces both press and release.
// For each accepted key it emits a hex code with a one-cycle valid pulse, and
// it keeps the last eight codes in a display-ready shift register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan4x4 #(
  parameter int unsigned SCAN_DIV       = 25000,
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned REPEAT_TICKS   = 500
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_pressed,
  output logic [31:0] key_data
);

  localparam int unsigned TCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DCW = 8;

  // Reject parameter values that the counters cannot represent
  if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_scan4x4: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_pressed_q, key_pressed_d;
  logic [31:0]      key_data_q, key_data_d;

  logic [3:0]       row_s1, row_s2;
  logic [TCW-1:0]   tcnt_q;
  logic             tick;
  logic             hit;
  logic [1:0]       hit_row;
  logic             latched_low;
  logic             emit;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RCW = $clog2(REPEAT_TICKS + 1);
  logic [RCW-1:0]   rcnt_q, rcnt_d;
`endif

  // Two-flop synchroniser for the asynchronous row pins
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  // Scan tick divider, parked at zero while disabled
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tcnt_q <= '0;
    end else if (!En || tcnt_q == TCW'(SCAN_DIV - 1)) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + TCW'(1);
    end
  end

  assign tick = En && (tcnt_q == TCW'(SCAN_DIV - 1));

  // Row priority encoder: the lowest-numbered low row wins
  always_comb begin
    hit_row = 2'd0;
    if (!row_s2[0])      hit_row = 2'd0;
    else if (!row_s2[1]) hit_row = 2'd1;
    else if (!row_s2[2]) hit_row = 2'd2;
    else if (!row_s2[3]) hit_row = 2'd3;
  end

  assign hit         = ~&row_s2;
  assign latched_low = ~row_s2[row_idx_q];

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= S_SCAN;
      col_q         <= 2'd0;
      row_idx_q     <= 2'd0;
      dcnt_q        <= '0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      key_data_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_idx_q     <= row_idx_d;
      dcnt_q        <= dcnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
      key_data_q    <= key_data_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat tick counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end
`endif

  // Next-state logic: scan, debounce press, hold, debounce release
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_idx_d     = row_idx_q;
    dcnt_d        = dcnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    key_data_d    = key_data_q;
    emit          = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rcnt_d        = rcnt_q;
`endif

    if (!En) begin
      state_d       = S_SCAN;
      col_d         = 2'd0;
      dcnt_d        = '0;
      key_pressed_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (hit) begin
            row_idx_d = hit_row;
            dcnt_d    = DCW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              emit    = 1'b1;
              state_d = S_HOLD;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (hit && hit_row == row_idx_q) begin
            dcnt_d = dcnt_q + DCW'(1);
            if (dcnt_q + DCW'(1) == DCW'(DEBOUNCE_TICKS)) begin
              emit    = 1'b1;
              state_d = S_HOLD;
            end
          end else begin
            dcnt_d  = '0;
            col_d   = col_q + 2'd1;
            state_d = S_SCAN;
          end
        end
        S_HOLD: begin
          if (!latched_low) begin
            dcnt_d = DCW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              key_pressed_d = 1'b0;
              col_d         = col_q + 2'd1;
              state_d       = S_SCAN;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rcnt_q + RCW'(1) == RCW'(REPEAT_TICKS)) begin
              emit   = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RCW'(1);
            end
`endif
          end
        end
        S_RELEASE: begin
          if (latched_low) begin
            dcnt_d  = '0;
            state_d = S_HOLD;
          end else begin
            dcnt_d = dcnt_q + DCW'(1);
            if (dcnt_q + DCW'(1) == DCW'(DEBOUNCE_TICKS)) begin
              dcnt_d        = '0;
              key_pressed_d = 1'b0;
              col_d         = col_q + 2'd1;
              state_d       = S_SCAN;
            end
          end
        end
        default: state_d = S_SCAN;
      endcase
    end

    // Accepted press or repeat: publish the code and shift it into history
    if (emit) begin
      key_valid_d   = 1'b1;
      key_code_d    = {row_idx_d, col_q};
      key_pressed_d = 1'b1;
      key_data_d    = {key_data_q[27:0], row_idx_d, col_q};
    end

`ifdef KEYPAD_REPEAT_EN
    // Repeat count restarts on every entry to or exit from HOLD
    if (state_q != S_HOLD || state_d != S_HOLD) rcnt_d = '0;
`endif
  end

  assign col_out     = En ? ~(4'(1) << col_q) : 4'hF;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;
  assign key_data    = key_data_q;

endmodule
